// File: rtl/mem_port_arbiter_if.sv
// Core fetch/data request ports plus the single-port SRAM pins, shared by the arbiter and its neighbours.
// The slave modport is the arbiter's view; the master modport is the core-and-SRAM side.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 10
);
  logic              I_REQ;
  logic [11:0]       I_ADDR;
  logic              I_GNT;
  logic              I_RVALID;
  logic [31:0]       I_RDATA;

  logic              D_REQ;
  logic              D_WEN;
  logic [3:0]        D_BE;
  logic [11:0]       D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_GNT;
  logic              D_RVALID;
  logic [31:0]       D_RDATA;

  logic              M_CSN;
  logic              M_WEN;
  logic [3:0]        M_BE;
  logic [AWIDTH-1:0] M_ADDR;
  logic [31:0]       M_DI;
  logic [31:0]       M_DOUT;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA, M_DOUT,
    output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WEN, D_BE, D_ADDR, D_WDATA, M_DOUT,
    input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
           M_CSN, M_WEN, M_BE, M_ADDR, M_DI
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter sharing one SP SRAM between fetch and data; grant is same-cycle, read data one cycle later.
// Losers hold their request until granted; data wins conflicts unless fetch is owed a turn. ARB_STATS_EN adds grant/conflict counters.
module mem_port_arbiter #(
  parameter int AWIDTH       = 10,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  mem_port_arbiter_if.slave    bus,
  output logic [31:0]          I_GNT_CNT,
  output logic [31:0]          D_GNT_CNT,
  output logic [31:0]          CONFLICT_CNT
);

  typedef enum logic {PRI_D, PRI_I} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q;
  logic [3:0]        starve_q;
  logic              rsp_vld_q;
  logic              rsp_d_q;
  logic [AWIDTH-1:0] addr_q;
  logic [31:0]       di_q;

  logic              conflict;
  logic              gnt_i;
  logic              gnt_d;
  logic              d_wr;
  logic [AWIDTH-1:0] addr_d;
  logic [31:0]       di_d;
  logic              unused_addr_bits;

  assign conflict = bus.I_REQ & bus.D_REQ;
  // Grants are masked while reset is held so the SRAM stays deselected.
  assign gnt_i    = RSTn & bus.I_REQ & (~bus.D_REQ | (state_q == PRI_I));
  assign gnt_d    = RSTn & bus.D_REQ & ~gnt_i;
  assign d_wr     = gnt_d & ~bus.D_WEN;

  always_comb begin
    addr_d = addr_q;
    di_d   = di_q;
    if (gnt_i) begin
      addr_d = bus.I_ADDR[AWIDTH+1:2];
    end else if (gnt_d) begin
      addr_d = bus.D_ADDR[AWIDTH+1:2];
    end
    if (d_wr) begin
      di_d = bus.D_WDATA;
    end
  end

  assign bus.I_GNT    = gnt_i;
  assign bus.D_GNT    = gnt_d;
  assign bus.M_CSN    = ~(gnt_i | gnt_d);
  assign bus.M_WEN    = ~d_wr;
  assign bus.M_BE     = d_wr ? bus.D_BE : 4'b0000;
  assign bus.M_ADDR   = addr_d;
  assign bus.M_DI     = di_d;

  assign bus.I_RVALID = rsp_vld_q & ~rsp_d_q;
  assign bus.D_RVALID = rsp_vld_q & rsp_d_q;
  assign bus.I_RDATA  = bus.I_RVALID ? bus.M_DOUT : 32'd0;
  assign bus.D_RDATA  = bus.D_RVALID ? bus.M_DOUT : 32'd0;

  // Byte-offset bits and any bits above the SRAM depth are dropped on purpose.
  assign unused_addr_bits = ^{bus.I_ADDR, bus.D_ADDR};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q   <= PRI_D;
      starve_q  <= 4'd0;
      rsp_vld_q <= 1'b0;
      rsp_d_q   <= 1'b0;
      addr_q    <= '0;
      di_q      <= 32'd0;
    end else begin
      addr_q    <= addr_d;
      di_q      <= di_d;
      rsp_vld_q <= gnt_i | (gnt_d & bus.D_WEN);
      rsp_d_q   <= gnt_d;
      case (state_q)
        PRI_D: begin
          if (gnt_i) begin
            starve_q <= 4'd0;
          end else if (conflict) begin
            starve_q <= starve_q + 4'd1;
            if (starve_q + 4'd1 == LIMIT) begin
              state_q <= PRI_I;
            end
          end
        end
        PRI_I: begin
          if (gnt_i) begin
            starve_q <= 4'd0;
            state_q  <= PRI_D;
          end
        end
        default: state_q <= PRI_D;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [31:0] i_cnt_q;
  logic [31:0] d_cnt_q;
  logic [31:0] c_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      i_cnt_q <= 32'd0;
      d_cnt_q <= 32'd0;
      c_cnt_q <= 32'd0;
    end else begin
      if (gnt_i) begin
        i_cnt_q <= i_cnt_q + 32'd1;
      end
      if (gnt_d) begin
        d_cnt_q <= d_cnt_q + 32'd1;
      end
      if (conflict) begin
        c_cnt_q <= c_cnt_q + 32'd1;
      end
    end
  end

  assign I_GNT_CNT    = i_cnt_q;
  assign D_GNT_CNT    = d_cnt_q;
  assign CONFLICT_CNT = c_cnt_q;
`else
  assign I_GNT_CNT    = 32'd0;
  assign D_GNT_CNT    = 32'd0;
  assign CONFLICT_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with an SRAM model and a per-cycle reference model of the sharing policy.
module tb_mem_port_arbiter;
  localparam int AW    = 10;
  localparam int SL    = 4;
  localparam int DEPTH = 1 << AW;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] i_gnt_cnt;
  logic [31:0] d_gnt_cnt;
  logic [31:0] conflict_cnt;
  int          checks = 0;
  int          errors = 0;
  string       seq;

  always #5 CLK = ~CLK;

  mem_port_arbiter_if #(.AWIDTH(AW)) bus ();

  mem_port_arbiter #(.AWIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .bus          (bus),
    .I_GNT_CNT    (i_gnt_cnt),
    .D_GNT_CNT    (d_gnt_cnt),
    .CONFLICT_CNT (conflict_cnt)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'hDEADBEEF;
      1:       return 32'h00500093;
      2:       return 32'h0BADF00D;
      4:       return 32'h11223344;
      default: return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // SRAM model: synchronous, byte-enabled writes, read data appears after the edge.
  logic [31:0] sram [DEPTH];
  bit          sram_loaded = 1'b0;
  always @(posedge CLK) begin
    if (!sram_loaded) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= init_word(i);
      sram_loaded <= 1'b1;
    end else if (!bus.M_CSN) begin
      if (!bus.M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (bus.M_BE[b]) sram[bus.M_ADDR][8*b +: 8] <= bus.M_DI[8*b +: 8];
      end else begin
        bus.M_DOUT <= sram[bus.M_ADDR];
      end
    end
  end

  // Reference model: who should be served, and what the SRAM pins and responses must be.
  logic [31:0] ref_mem [DEPTH];
  bit          ref_loaded = 1'b0;
  int          lose_streak;
  bit          fetch_owed;
  int          rsp_kind;      // 0 none, 1 fetch, 2 data
  logic [31:0] rsp_word;
  logic [31:0] last_addr;
  logic [31:0] last_di;
  logic [31:0] n_i, n_d, n_c;
  int          winner;
  int          word;
  bit          is_wr;

  always @(negedge CLK) begin
    if (!ref_loaded) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
      ref_loaded = 1'b1;
    end
    if (!RSTn) begin
      chk("rst_i_gnt",    32'(bus.I_GNT),    32'd0);
      chk("rst_d_gnt",    32'(bus.D_GNT),    32'd0);
      chk("rst_m_csn",    32'(bus.M_CSN),    32'd1);
      chk("rst_m_wen",    32'(bus.M_WEN),    32'd1);
      chk("rst_m_be",     32'(bus.M_BE),     32'd0);
      chk("rst_m_addr",   32'(bus.M_ADDR),   32'd0);
      chk("rst_m_di",     bus.M_DI,          32'd0);
      chk("rst_i_rvalid", 32'(bus.I_RVALID), 32'd0);
      chk("rst_d_rvalid", 32'(bus.D_RVALID), 32'd0);
      chk("rst_i_cnt",    i_gnt_cnt,         32'd0);
      chk("rst_d_cnt",    d_gnt_cnt,         32'd0);
      chk("rst_c_cnt",    conflict_cnt,      32'd0);
      lose_streak = 0;
      fetch_owed  = 1'b0;
      rsp_kind    = 0;
      rsp_word    = 32'd0;
      last_addr   = 32'd0;
      last_di     = 32'd0;
      n_i = 32'd0;
      n_d = 32'd0;
      n_c = 32'd0;
    end else begin
      chk("i_rvalid", 32'(bus.I_RVALID), (rsp_kind == 1) ? 32'd1 : 32'd0);
      chk("d_rvalid", 32'(bus.D_RVALID), (rsp_kind == 2) ? 32'd1 : 32'd0);
      chk("i_rdata",  bus.I_RDATA, (rsp_kind == 1) ? rsp_word : 32'd0);
      chk("d_rdata",  bus.D_RDATA, (rsp_kind == 2) ? rsp_word : 32'd0);
`ifdef ARB_STATS_EN
      chk("i_gnt_cnt",    i_gnt_cnt,    n_i);
      chk("d_gnt_cnt",    d_gnt_cnt,    n_d);
      chk("conflict_cnt", conflict_cnt, n_c);
`else
      chk("i_gnt_cnt",    i_gnt_cnt,    32'd0);
      chk("d_gnt_cnt",    d_gnt_cnt,    32'd0);
      chk("conflict_cnt", conflict_cnt, 32'd0);
`endif
      winner = 0;
      if (bus.I_REQ && (!bus.D_REQ || fetch_owed)) winner = 1;
      else if (bus.D_REQ) winner = 2;
      is_wr = (winner == 2) && !bus.D_WEN;
      word  = (winner == 1) ? (int'(bus.I_ADDR) / 4) % DEPTH : (int'(bus.D_ADDR) / 4) % DEPTH;
      if (winner != 0) last_addr = 32'(word);
      if (is_wr) last_di = bus.D_WDATA;

      chk("i_gnt",  32'(bus.I_GNT),  (winner == 1) ? 32'd1 : 32'd0);
      chk("d_gnt",  32'(bus.D_GNT),  (winner == 2) ? 32'd1 : 32'd0);
      chk("m_csn",  32'(bus.M_CSN),  (winner == 0) ? 32'd1 : 32'd0);
      chk("m_wen",  32'(bus.M_WEN),  is_wr ? 32'd0 : 32'd1);
      chk("m_be",   32'(bus.M_BE),   is_wr ? 32'(bus.D_BE) : 32'd0);
      chk("m_addr", 32'(bus.M_ADDR), last_addr);
      chk("m_di",   bus.M_DI,        last_di);

      rsp_kind = 0;
      if (winner == 1 || (winner == 2 && bus.D_WEN)) begin
        rsp_kind = winner;
        rsp_word = ref_mem[word];
      end
      if (is_wr)
        for (int b = 0; b < 4; b++)
          if (bus.D_BE[b]) ref_mem[word][8*b +: 8] = bus.D_WDATA[8*b +: 8];

      if (bus.I_REQ && bus.D_REQ) n_c = n_c + 32'd1;
      if (winner == 1) begin
        n_i = n_i + 32'd1;
        lose_streak = 0;
        fetch_owed  = 1'b0;
      end else if (winner == 2) begin
        n_d = n_d + 32'd1;
        if (bus.I_REQ) begin
          lose_streak++;
          if (lose_streak >= SL) fetch_owed = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.I_REQ = 1'b0;
    bus.D_REQ = 1'b0;
    bus.D_WEN = 1'b1;
    bus.D_BE  = 4'b0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RSTn = 1'b0;
    bus.I_ADDR  = 12'h000;
    bus.D_ADDR  = 12'h000;
    bus.D_WDATA = 32'd0;
    idle();
    repeat (3) step();
    RSTn = 1'b1;
    step();

    // Lone fetch of word 1.
    bus.I_REQ = 1'b1; bus.I_ADDR = 12'h004;
    @(negedge CLK);
    chk("t1_i_gnt",  32'(bus.I_GNT),  32'd1);
    chk("t1_m_addr", 32'(bus.M_ADDR), 32'd1);
    chk("t1_m_csn",  32'(bus.M_CSN),  32'd0);
    chk("t1_m_wen",  32'(bus.M_WEN),  32'd1);
    step(); idle();
    @(negedge CLK);
    chk("t1_i_rvalid", 32'(bus.I_RVALID), 32'd1);
    chk("t1_i_rdata",  bus.I_RDATA,       32'h00500093);
    step();

    // Partial write then read back word 4.
    bus.D_REQ = 1'b1; bus.D_WEN = 1'b0; bus.D_ADDR = 12'h010;
    bus.D_BE = 4'b0011; bus.D_WDATA = 32'hAABBCCDD;
    @(negedge CLK);
    chk("t2_d_gnt", 32'(bus.D_GNT), 32'd1);
    chk("t2_m_wen", 32'(bus.M_WEN), 32'd0);
    chk("t2_m_be",  32'(bus.M_BE),  32'h3);
    step();
    bus.D_WEN = 1'b1; bus.D_BE = 4'b0000;
    step(); idle();
    @(negedge CLK);
    chk("t2_d_rvalid", 32'(bus.D_RVALID), 32'd1);
    chk("t2_d_rdata",  bus.D_RDATA,       32'h1122CCDD);
    step();

    // Back-to-back data read then fetch.
    bus.D_REQ = 1'b1; bus.D_ADDR = 12'h000;
    step();
    bus.D_REQ = 1'b0; bus.I_REQ = 1'b1; bus.I_ADDR = 12'h008;
    @(negedge CLK);
    chk("t3_d_rvalid", 32'(bus.D_RVALID), 32'd1);
    chk("t3_d_rdata",  bus.D_RDATA,       32'hDEADBEEF);
    chk("t3_i_rvalid", 32'(bus.I_RVALID), 32'd0);
    step(); idle();
    @(negedge CLK);
    chk("t3_i_rvalid2", 32'(bus.I_RVALID), 32'd1);
    chk("t3_i_rdata",   bus.I_RDATA,       32'h0BADF00D);
    chk("t3_d_rvalid2", 32'(bus.D_RVALID), 32'd0);
    step();

    // Top-of-memory address, byte offset ignored.
    bus.I_REQ = 1'b1; bus.I_ADDR = 12'hFFF;
    @(negedge CLK);
    chk("t4_m_addr", 32'(bus.M_ADDR), 32'h3FF);
    step(); idle();
    step();

    // Fetch owed a turn keeps priority across data-only cycles.
    bus.I_REQ = 1'b1; bus.I_ADDR = 12'h020;
    bus.D_REQ = 1'b1; bus.D_ADDR = 12'h040;
    for (int c = 0; c < SL; c++) begin
      @(negedge CLK);
      chk("t5_d_wins", 32'(bus.D_GNT), 32'd1);
      step();
    end
    bus.I_REQ = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      chk("t5_d_alone", 32'(bus.D_GNT), 32'd1);
      step();
    end
    bus.I_REQ = 1'b1;
    @(negedge CLK);
    chk("t5_i_owed", 32'(bus.I_GNT), 32'd1);
    chk("t5_d_held", 32'(bus.D_GNT), 32'd0);
    step(); idle();
    step();

    // Reset one cycle after a granted read.
    bus.D_REQ = 1'b1; bus.D_ADDR = 12'h000;
    step(); idle();
    RSTn = 1'b0;
    @(negedge CLK);
    chk("t6_d_rvalid_rst", 32'(bus.D_RVALID), 32'd0);
    step(); step();
    RSTn = 1'b1;
    @(negedge CLK);
    chk("t6_d_rvalid_rel", 32'(bus.D_RVALID), 32'd0);
    chk("t6_i_rvalid_rel", 32'(bus.I_RVALID), 32'd0);
    chk("t6_m_csn_rel",    32'(bus.M_CSN),    32'd1);
    step();

    // Sustained conflict from a clean reset.
    bus.I_REQ = 1'b1; bus.I_ADDR = 12'h020;
    bus.D_REQ = 1'b1; bus.D_ADDR = 12'h040; bus.D_WEN = 1'b1;
    seq = "";
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (bus.I_GNT && !bus.D_GNT)      seq = {seq, "I"};
      else if (bus.D_GNT && !bus.I_GNT) seq = {seq, "D"};
      else                              seq = {seq, "-"};
      step();
    end
    idle();
    checks++;
    if (seq != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL t7_grant_seq: got %s expected DDDDIDDDDI", seq);
    end
    @(negedge CLK);
`ifdef ARB_STATS_EN
    chk("t7_conflict_cnt", conflict_cnt, 32'd10);
    chk("t7_d_gnt_cnt",    d_gnt_cnt,    32'd8);
    chk("t7_i_gnt_cnt",    i_gnt_cnt,    32'd2);
`else
    chk("t7_conflict_cnt", conflict_cnt, 32'd0);
    chk("t7_d_gnt_cnt",    d_gnt_cnt,    32'd0);
    chk("t7_i_gnt_cnt",    i_gnt_cnt,    32'd0);
`endif
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
